// File: rtl/datapath_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | datapath_ctrl: Moore sequencer for the 16-bit register/ALU datapath.         |
// | Optional: DATAPATH_CTRL_ILLEGAL_TRAP_EN makes illegal opcodes trap (sticky). |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module datapath_ctrl #(
  parameter int WIDTH      = 16,
  parameter int SIZE       = 8,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [WIDTH-1:0]      imm,
  output logic                  vsel,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] writenum,
  output logic [ADDR_WIDTH-1:0] readnum1,
  output logic [ADDR_WIDTH-1:0] readnum2,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic                  bsel,
  output logic [1:0]            shift,
  output logic [1:0]            aluop,
  output logic                  done,
  output logic                  halted,
  output logic                  trap
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WIMM = 3'd1,
    S_LOAD = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ILL  = 3'd6
  } state_e;

  localparam logic [2:0] C_OPC_ALU  = 3'b101;
  localparam logic [2:0] C_OPC_MOV  = 3'b110;
  localparam logic [2:0] C_OPC_HALT = 3'b111;

  state_e      state_q, state_d;
  logic [15:0] instr_q;
  logic        w_accept;

  logic [2:0]  w_opc;
  logic [1:0]  w_op;
  logic        w_is_alu;

  assign w_accept = instr_valid && (state_q == S_IDLE);
  assign w_opc    = instr_q[15:13];
  assign w_op     = instr_q[12:11];
  assign w_is_alu = (w_opc == C_OPC_ALU);

  // Dispatch must look at the incoming word so MOV imm can retire one edge after acceptance.
  function automatic state_e f_dispatch(input logic [4:0] oc);
    state_e s;
    s = S_ILL;
    case (oc[4:2])
      C_OPC_MOV: begin
        if (oc[1:0] == 2'b10)      s = S_WIMM;
        else if (oc[1:0] == 2'b00) s = S_LOAD;
        else                       s = S_ILL;
      end
      C_OPC_ALU:  s = S_LOAD;
      C_OPC_HALT: s = S_HALT;
      default:    s = S_ILL;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (w_accept) instr_q <= instr;
    end
  end

  assign imm = WIDTH'($signed(instr_q[7:0]));

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    vsel        = 1'b0;
    write       = 1'b0;
    writenum    = '0;
    readnum1    = '0;
    readnum2    = '0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = 2'b00;
    aluop       = 2'b00;
    done        = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = f_dispatch(instr[15:11]);
      end
      S_WIMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = ADDR_WIDTH'(instr_q[10:8]);
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_LOAD: begin
        readnum1 = ADDR_WIDTH'(instr_q[10:8]);
        readnum2 = ADDR_WIDTH'(instr_q[2:0]);
        loada    = 1'b1;
        loadb    = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        shift = instr_q[4:3];
        bsel  = 1'b1;
        // MOV reg and MVN run with a zero A operand; MOV reg forces ADD.
        if (w_is_alu) begin
          aluop = w_op;
          asel  = (w_op != 2'b11);
        end
        if (w_is_alu && (w_op == 2'b01)) begin
          loads   = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          loadc   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        write    = 1'b1;
        writenum = ADDR_WIDTH'(instr_q[7:5]);
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ILL: begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
        trap    = 1'b1;
`else
        done    = 1'b1;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/datapath_ctrl.md
# datapath_ctrl

Sequencing controller that drives the control side of the 16-bit register/ALU datapath. It accepts one instruction word at a time through a valid/ready handshake, decodes it, and steps a Moore state machine. The state machine emits the register-file read and write selects, the A/B/C/status load enables, the operand selects, the shift code, the ALU op and the sign-extended immediate in the cycle order the datapath requires. It sits between the instruction source and the datapath, one instance per datapath.

## Interface
- WIDTH, 16, datapath word width; the immediate is sign-extended to WIDTH.
- SIZE, 8, register count; ADDR_WIDTH = $clog2(SIZE) (must be ≥3 for the encoding below).

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr  input  16  instruction word
- instr_valid  input  1  instr is valid
- instr_ready  output  1  controller can accept instr
- imm  output  WIDTH  sign-extended imm8 to datapath data input
- vsel, write  output  1  writeback source (1=imm) / regfile write enable
- writenum, readnum1, readnum2  output  ADDR_WIDTH  register selects
- loada, loadb, loadc, loads  output  1  A/B/C/status load enables
- asel, bsel  output  1  1 = pass A / shifter output, 0 = zero operand
- shift, aluop  output  2  shift code / ALU op
- done  output  1  one-cycle pulse when an instruction retires
- halted  output  1  HALT executed, sticky
- trap  output  1  illegal opcode seen, sticky (macro only, else tied 0)

## Operation
- Encoding: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,sh(Rm), via asel=0, bsel=1, aluop=00
  - 101/00 ADD Rd,Rn,sh(Rm)
  - 101/01 CMP Rn,sh(Rm)
  - 101/10 AND Rd,Rn,sh(Rm)
  - 101/11 MVN Rd,sh(Rm), via asel=0
  - 111/xx HALT
  - Anything else is illegal.
- Handshake: transfer on the rising edge where instr_valid && instr_ready. instr is latched into an internal register, and all decode uses the latched copy. instr_ready = (state==IDLE).
- States and transitions:
  - IDLE → WIMM (MOV imm) | LOAD (ALU, MOV reg) | HALT | ILL.
  - WIMM: vsel=1, write=1, writenum=Rn. Next state IDLE, done=1.
  - LOAD: readnum1=Rn, readnum2=Rm, loada=1, loadb=1. Next state EXEC.
  - EXEC: shift=sh, aluop=op (00 for MOV reg), asel/bsel per instruction, loadc=1. CMP: loadc=0, loads=1, next IDLE with done=1. Others: next WB.
  - WB: vsel=0, write=1, writenum=Rd. Next IDLE, done=1.
  - HALT: halted=1, instr_ready=0; stays until reset.
  - ILL: see Configuration.
- Output values by state:
  - Every control output not listed for a state is 0.
  - imm = sign-extended imm8 of the latched instruction in every state.
  - Outputs are Moore outputs (state + latched instr); there are no combinational paths from instr.
- Reset value of every output:
  - instr_ready = 1.
  - All other outputs and imm = 0.
  - State = IDLE; latched instr = 0.

## Timing
- Cycles from the acceptance edge to the edge ending the retiring state (done high in that final cycle):
  - MOV imm: 1
  - CMP: 2
  - ADD, AND, MVN, MOV reg: 3
- Back-to-back: the next instruction may be accepted in the first IDLE cycle after done. There is no overlap between instructions.
- instr_valid while not ready: ignored; the source must hold it.
- rst_n low at any time, including mid-instruction: outputs reach their reset values immediately (asynchronously). The in-flight instruction is abandoned with no write and no done.
- Reset deassertion is synchronized by the system; first acceptance is possible on the first edge with rst_n high.

## Configuration
- DATAPATH_CTRL_ILLEGAL_TRAP_EN defined:
  - An illegal opcode enters ILL; trap=1 and instr_ready=0 until reset.
  - done is not pulsed.
- DATAPATH_CTRL_ILLEGAL_TRAP_EN undefined:
  - ILL lasts one cycle with no control asserted, then returns to IDLE with done=1 (NOP).
  - trap is tied 0.

## Test plan
- Reset, then 0xD007 (MOV R0,#7) → next cycle: vsel=1, write=1, writenum=0, imm=0x0007, done=1; then instr_ready=1.
- 0xD1FE (MOV R1,#-2) → imm=0xFFFE, writenum=1, write=1.
- 0xA049 (ADD R2,R0,R1 LSL1) → LOAD: readnum1=0, readnum2=1, loada=loadb=1. EXEC: asel=bsel=1, shift=01, aluop=00, loadc=1, loads=0. WB: writenum=2, write=1, vsel=0, done=1. Three cycles total.
- 0xA801 (CMP R0,R1) → EXEC: loads=1, loadc=0; write never asserted; done at cycle 2. Follow with 0xE000 → halted=1, instr_ready stays 0 over 10 cycles with instr_valid high.
- 0x0000 (illegal): with macro → trap=1, instr_ready=0 persistent. Without macro → one idle cycle, done=1, trap=0, next instruction accepted.
- Pull rst_n low in the EXEC cycle of 0xA049 → loadc/write drop to 0 immediately, no done. After release, instr_ready=1 and 0xD007 executes normally.
